// File: rtl/mannix_job_sched.sv
// mannix_job_sched: in-order job queue that launches jobs on the CNN, POOL and
// FCC engines. It tracks each engine from go through busy to completion, then
// reports finished jobs one at a time, with illegal jobs first and then CNN >
// POOL > FCC.
module mannix_job_sched #(
    parameter int CMD_DEPTH     = 8,
    parameter int ID_WIDTH      = 4,
    parameter int START_TIMEOUT = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_eng,
    input  logic                         cmd_barrier,
    input  logic [ID_WIDTH-1:0]          cmd_id,
    output logic [2:0]                   eng_go,
    input  logic [2:0]                   eng_busy,
    output logic                         done_valid,
    output logic [ID_WIDTH-1:0]          done_id,
    output logic                         done_err,
    output logic [$clog2(CMD_DEPTH):0]   q_count,
    output logic                         sched_busy
);

    localparam int PW = $clog2(CMD_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_ARM,
        S_RUN,
        S_DONE
    } eng_state_t;

    // Command queue storage and bookkeeping
    logic [1:0]          q_eng [CMD_DEPTH];
    logic                q_bar [CMD_DEPTH];
    logic [ID_WIDTH-1:0] q_id  [CMD_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic [CW-1:0]       count_nxt;

    // Per-engine tracking
    eng_state_t          state     [3];
    eng_state_t          state_nxt [3];
    logic [ID_WIDTH-1:0] eng_id    [3];
    logic [TW-1:0]       arm_cnt   [3];
    logic                eng_err   [3];
    logic [2:0]          timeout;

    // Illegal-job completion slot
    logic                ill_pend;
    logic                ill_pend_nxt;
    logic [ID_WIDTH-1:0] ill_id;

    // Dispatch and completion-select wires
    logic                push;
    logic                pop_any;
    logic                pop_ill;
    logic [2:0]          launch;
    logic [1:0]          head_eng;
    logic                head_bar;
    logic [ID_WIDTH-1:0] head_id;
    logic                all_idle;
    logic                barrier_ok;
    logic                sel_ill;
    logic [2:0]          sel;
    logic                sel_any;
    logic [ID_WIDTH-1:0] sel_id;
    logic                sel_err;
    logic                any_active_nxt;

    assign cmd_ready  = (count < CW'(CMD_DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign q_count    = count;
    assign head_eng   = q_eng[rd_ptr];
    assign head_bar   = q_bar[rd_ptr];
    assign head_id    = q_id[rd_ptr];
    assign all_idle   = (state[0] == S_IDLE) && (state[1] == S_IDLE) && (state[2] == S_IDLE);
    assign barrier_ok = !head_bar || (all_idle && !ill_pend && (eng_busy == 3'b000));
    assign pop_any    = pop_ill || (launch != 3'b000);

    // Queue payload write; storage needs no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            q_eng[wr_ptr] <= cmd_eng;
            q_bar[wr_ptr] <= cmd_barrier;
            q_id[wr_ptr]  <= cmd_id;
        end
    end

    // Next occupancy from this cycle's push and pop
    always_comb begin
        count_nxt = count;
        case ({push, pop_any})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Queue pointers and occupancy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop_any) rd_ptr <= rd_ptr + PW'(1);
            count <= count_nxt;
        end
    end

    // Head-of-queue dispatch: in order, at most one pop per cycle
    always_comb begin
        launch  = 3'b000;
        pop_ill = 1'b0;
        if ((count != '0) && barrier_ok) begin
            if (head_eng == 2'd3) begin
                pop_ill = 1'b1;
            end else begin
                for (int e = 0; e < 3; e++) begin
                    if ((head_eng == 2'(e)) && (state[e] == S_IDLE) && !eng_busy[e]) begin
                        launch[e] = 1'b1;
                    end
                end
            end
        end
    end

    // Completion select: the illegal slot wins, then CNN, POOL, FCC
    always_comb begin
        sel_ill = 1'b0;
        sel     = 3'b000;
        sel_id  = '0;
        sel_err = 1'b0;
        if (ill_pend) begin
            sel_ill = 1'b1;
            sel_id  = ill_id;
            sel_err = 1'b1;
        end else if (state[0] == S_DONE) begin
            sel[0]  = 1'b1;
            sel_id  = eng_id[0];
            sel_err = eng_err[0];
        end else if (state[1] == S_DONE) begin
            sel[1]  = 1'b1;
            sel_id  = eng_id[1];
            sel_err = eng_err[1];
        end else if (state[2] == S_DONE) begin
            sel[2]  = 1'b1;
            sel_id  = eng_id[2];
            sel_err = eng_err[2];
        end
        sel_any = sel_ill || (sel != 3'b000);
    end

    // Per-engine next-state: launch, wait for busy (or time out), run, report
    always_comb begin
        for (int e = 0; e < 3; e++) begin
            state_nxt[e] = state[e];
            timeout[e]   = ((arm_cnt[e] + TW'(1)) == TW'(START_TIMEOUT));
            case (state[e])
                S_IDLE:   if (launch[e]) state_nxt[e] = S_LAUNCH;
                S_LAUNCH: state_nxt[e] = S_ARM;
                S_ARM: begin
                    if (eng_busy[e]) state_nxt[e] = S_RUN;
                    else if (timeout[e]) state_nxt[e] = S_DONE;
                end
                S_RUN:    if (!eng_busy[e]) state_nxt[e] = S_DONE;
                S_DONE:   if (sel[e]) state_nxt[e] = S_IDLE;
                default:  state_nxt[e] = S_IDLE;
            endcase
        end
    end

    // Per-engine state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < 3; e++) state[e] <= S_IDLE;
        end else begin
            for (int e = 0; e < 3; e++) state[e] <= state_nxt[e];
        end
    end

    // Per-engine job ID, arm counter and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < 3; e++) begin
                eng_id[e]  <= '0;
                arm_cnt[e] <= '0;
                eng_err[e] <= 1'b0;
            end
        end else begin
            for (int e = 0; e < 3; e++) begin
                if (launch[e]) begin
                    eng_id[e]  <= head_id;
                    eng_err[e] <= 1'b0;
                end
                if (state[e] == S_LAUNCH) begin
                    arm_cnt[e] <= '0;
                end else if ((state[e] == S_ARM) && !eng_busy[e]) begin
                    arm_cnt[e] <= arm_cnt[e] + TW'(1);
                    if (timeout[e]) eng_err[e] <= 1'b1;
                end
            end
        end
    end

    // Next value of the illegal slot; a new illegal pop overrides the clear
    always_comb begin
        ill_pend_nxt = ill_pend;
        if (pop_ill) ill_pend_nxt = 1'b1;
        else if (sel_ill) ill_pend_nxt = 1'b0;
        any_active_nxt = (state_nxt[0] != S_IDLE) || (state_nxt[1] != S_IDLE) ||
                         (state_nxt[2] != S_IDLE);
    end

    // Illegal-job slot register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_pend <= 1'b0;
            ill_id   <= '0;
        end else begin
            ill_pend <= ill_pend_nxt;
            if (pop_ill) ill_id <= head_id;
        end
    end

    // Registered outputs: go pulses, completion report and overall busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_go     <= 3'b000;
            done_valid <= 1'b0;
            done_id    <= '0;
            done_err   <= 1'b0;
            sched_busy <= 1'b0;
        end else begin
            eng_go     <= launch;
            done_valid <= sel_any;
            done_id    <= sel_id;
            done_err   <= sel_err;
            sched_busy <= (count_nxt != '0) || any_active_nxt || ill_pend_nxt;
        end
    end

endmodule

// File: tb/tb_mannix_job_sched.sv
// Directed bench for mannix_job_sched: every expected value below is
// hand-derived cycle by cycle from the scheduler's timing rules.
module tb_mannix_job_sched;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_eng;
    logic       cmd_barrier;
    logic [3:0] cmd_id;
    logic [2:0] eng_go;
    logic [2:0] eng_busy;
    logic       done_valid;
    logic [3:0] done_id;
    logic       done_err;
    logic [3:0] q_count;
    logic       sched_busy;

    int n_cmp;
    int n_err;
    int n_done;

    mannix_job_sched #(
        .CMD_DEPTH     (8),
        .ID_WIDTH      (4),
        .START_TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_eng     (cmd_eng),
        .cmd_barrier (cmd_barrier),
        .cmd_id      (cmd_id),
        .eng_go      (eng_go),
        .eng_busy    (eng_busy),
        .done_valid  (done_valid),
        .done_id     (done_id),
        .done_err    (done_err),
        .q_count     (q_count),
        .sched_busy  (sched_busy)
    );

    // Free-running 10-time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic [1:0] eng,
                                  input logic bar, input logic [3:0] id);
        cmd_valid   = valid;
        cmd_eng     = eng;
        cmd_barrier = bar;
        cmd_id      = id;
    endtask

    // Directed sequence of scenarios
    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        eng_busy = 3'b000;
        apply_stimulus(1'b0, 2'd0, 1'b0, 4'd0);
        tick();
        tick();
        check_output("rst_ready", cmd_ready, 1);
        check_output("rst_go", eng_go, 0);
        check_output("rst_done", done_valid, 0);
        check_output("rst_qcount", q_count, 0);
        check_output("rst_busy", sched_busy, 0);
        rst_n = 1'b1;
        tick();

        // Single CNN job id=5, busy during cycles 3..12 (push at cycle 0)
        for (int i = 0; i < 18; i++) begin
            if (i == 0) apply_stimulus(1'b1, 2'd0, 1'b0, 4'd5);
            else apply_stimulus(1'b0, 2'd0, 1'b0, 4'd0);
            eng_busy[0] = (i >= 3 && i <= 12);
            check_output("t1_go", eng_go, (i == 2) ? 3'b001 : 3'b000);
            check_output("t1_dv", done_valid, (i == 15) ? 1 : 0);
            if (i == 15) begin
                check_output("t1_id", done_id, 5);
                check_output("t1_err", done_err, 0);
            end
            if (i == 1) check_output("t1_q1", q_count, 1);
            if (i == 2) check_output("t1_q0", q_count, 0);
            if (i == 5) check_output("t1_sbusy1", sched_busy, 1);
            if (i == 16) check_output("t1_sbusy0", sched_busy, 0);
            tick();
        end

        // CNN id1, POOL id2, barrier POOL id3; CNN busy 20, POOL busy 5
        for (int i = 0; i < 34; i++) begin
            case (i)
                0:       apply_stimulus(1'b1, 2'd0, 1'b0, 4'd1);
                1:       apply_stimulus(1'b1, 2'd1, 1'b0, 4'd2);
                2:       apply_stimulus(1'b1, 2'd1, 1'b1, 4'd3);
                default: apply_stimulus(1'b0, 2'd0, 1'b0, 4'd0);
            endcase
            eng_busy[0] = (i >= 3 && i <= 22);
            eng_busy[1] = (i >= 4 && i <= 8) || (i >= 27 && i <= 28);
            check_output("t2_go", eng_go,
                         (i == 2) ? 3'b001 : (i == 3 || i == 26) ? 3'b010 : 3'b000);
            check_output("t2_dv", done_valid, (i == 11 || i == 25 || i == 31) ? 1 : 0);
            if (i == 11) check_output("t2_id2", done_id, 2);
            if (i == 25) check_output("t2_id1", done_id, 1);
            if (i == 31) check_output("t2_id3", done_id, 3);
            if (i == 31) check_output("t2_err3", done_err, 0);
            if (i == 24) check_output("t2_qwait", q_count, 1);
            if (i == 33) check_output("t2_sbusy0", sched_busy, 0);
            tick();
        end

        // CNN id6 and FCC id7 with busy falling in the same cycle
        for (int i = 0; i < 16; i++) begin
            case (i)
                0:       apply_stimulus(1'b1, 2'd0, 1'b0, 4'd6);
                1:       apply_stimulus(1'b1, 2'd2, 1'b0, 4'd7);
                default: apply_stimulus(1'b0, 2'd0, 1'b0, 4'd0);
            endcase
            eng_busy[0] = (i >= 3 && i <= 9);
            eng_busy[2] = (i >= 4 && i <= 9);
            check_output("t3_go", eng_go,
                         (i == 2) ? 3'b001 : (i == 3) ? 3'b100 : 3'b000);
            check_output("t3_dv", done_valid, (i == 12 || i == 13) ? 1 : 0);
            if (i == 12) check_output("t3_id_cnn", done_id, 6);
            if (i == 13) check_output("t3_id_fcc", done_id, 7);
            if (i == 15) check_output("t3_sbusy0", sched_busy, 0);
            tick();
        end

        // FCC id9 whose busy never rises, then illegal eng=3 id10
        eng_busy = 3'b000;
        for (int i = 0; i < 12; i++) begin
            case (i)
                0:       apply_stimulus(1'b1, 2'd2, 1'b0, 4'd9);
                1:       apply_stimulus(1'b1, 2'd3, 1'b0, 4'd10);
                default: apply_stimulus(1'b0, 2'd0, 1'b0, 4'd0);
            endcase
            check_output("t4_go", eng_go, (i == 2) ? 3'b100 : 3'b000);
            check_output("t4_dv", done_valid, (i == 4 || i == 8) ? 1 : 0);
            if (i == 4) begin
                check_output("t4_ill_id", done_id, 10);
                check_output("t4_ill_err", done_err, 1);
            end
            if (i == 8) begin
                check_output("t4_to_id", done_id, 9);
                check_output("t4_to_err", done_err, 1);
            end
            tick();
        end

        // Fill the queue behind a stalled CNN; the 9th push must be dropped
        eng_busy = 3'b001;
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(1'b1, 2'd0, 1'b0, 4'(i));
            check_output("t5_qcount", q_count, i);
            check_output("t5_ready", cmd_ready, (i < 8) ? 1 : 0);
            tick();
        end
        apply_stimulus(1'b0, 2'd0, 1'b0, 4'd0);
        eng_busy = 3'b000;
        check_output("t5_full", q_count, 8);
        n_done = 0;
        for (int j = 0; j < 80; j++) begin
            tick();
            if (done_valid) begin
                check_output("t5_order", done_id, 4'(n_done));
                check_output("t5_err", done_err, 1);
                n_done++;
            end
        end
        check_output("t5_ndone", n_done, 8);
        check_output("t5_drained", q_count, 0);

        // Reset while CNN runs with three jobs queued behind it
        for (int i = 0; i < 9; i++) begin
            if (i <= 3) apply_stimulus(1'b1, 2'd0, 1'b0, 4'(i + 1));
            else apply_stimulus(1'b0, 2'd0, 1'b0, 4'd0);
            eng_busy[0] = (i >= 3);
            if (i == 8) begin
                check_output("t6_q3", q_count, 3);
                check_output("t6_sbusy", sched_busy, 1);
            end
            if (i < 8) tick();
        end
        rst_n = 1'b0;
        #2;
        check_output("t6_rst_q", q_count, 0);
        check_output("t6_rst_dv", done_valid, 0);
        check_output("t6_rst_go", eng_go, 0);
        check_output("t6_rst_sbusy", sched_busy, 0);
        tick();
        eng_busy = 3'b000;
        tick();
        rst_n = 1'b1;
        check_output("t6_ready", cmd_ready, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_output("t6_no_dv", done_valid, 0);
            check_output("t6_q_post", q_count, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mannix_job_sched.md
Name: mannix_job_sched

Overview:
Hardware job scheduler in front of the three mannix compute engines (CNN, POOL, FCC). Software pushes job commands into an in-order queue. The scheduler launches each job on its target engine with a one-cycle go pulse, then tracks that engine's busy indication through to completion and reports each finished job by ID. Engines run concurrently; an optional barrier bit orders dependent jobs (e.g. POOL after CNN).

Parameters:
CMD_DEPTH, 8, command queue depth (power of 2, >=2)
ID_WIDTH, 4, job ID width
START_TIMEOUT, 4, cycles to wait for busy to rise after go before treating the job as complete

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  queue can accept (count < CMD_DEPTH)
cmd_eng  input  2  target engine: 0=CNN, 1=POOL, 2=FCC, 3=illegal
cmd_barrier  input  1  dispatch only when all engines are idle and no completions are pending
cmd_id  input  ID_WIDTH  job tag
eng_go  output  3  one-cycle launch pulse per engine (bit0=CNN, bit1=POOL, bit2=FCC)
eng_busy  input  3  engine busy indications (cnn_sw_busy_ind, pool_sw_busy_ind, fc_sw_busy_ind)
done_valid  output  1  one-cycle completion pulse
done_id  output  ID_WIDTH  ID of the completed job
done_err  output  1  with done_valid: job completed via start timeout, or was illegal
q_count  output  $clog2(CMD_DEPTH)+1  queue occupancy
sched_busy  output  1  queue non-empty, or any engine not IDLE, or any completion pending

Behaviour:
- Reset: all outputs 0 except cmd_ready=1. Queue is emptied and every engine FSM returns to IDLE. Reset mid-job drops all in-flight state and reports nothing.
- Push:
  - Occurs when cmd_valid && cmd_ready, capturing {eng, barrier, id}.
  - A push and a pop in the same cycle are legal; count is unchanged.
  - A push when full is ignored; cmd_ready=0 in that case.
- Dispatch, evaluated each cycle on the queue head only (strictly in order). The head pops when:
  - the queue is non-empty, and
  - the target engine FSM is IDLE with eng_busy[e]=0, and
  - if the barrier bit is set: all FSMs are IDLE, no done is pending, and eng_busy==0.
- Go timing:
  - eng_go[e] is asserted in the cycle after the pop, for exactly 1 cycle. This is registered; there is no combinational path from cmd_* to eng_go.
  - At most one dispatch per cycle.
- Illegal head (eng=3): pops immediately, with no go. That FSM-free job is entered directly as a pending completion with err=1.
- Per-engine FSM (x3), which latches the job ID:
  - IDLE -> LAUNCH on dispatch.
  - LAUNCH (go=1, 1 cycle) -> ARM.
  - ARM: if busy=1 -> RUN. Otherwise a counter increments; when the count reaches START_TIMEOUT, go to DONE with err=1.
  - RUN: when busy=0 -> DONE with err=0.
  - DONE: holds the pending completion; -> IDLE in the cycle it is reported.
- Completion reporting:
  - At most one done_valid per cycle. Fixed priority: illegal-pending > CNN > POOL > FCC.
  - A losing completion stays pending, with no loss.
  - done_valid is registered: it asserts the cycle after a pending entry is selected.
- Minimum latency for a legal job whose busy rises in the cycle after go:
  - pop at T, go at T+1, busy at T+2;
  - with busy falling at cycle F: DONE at F+1, done_valid at F+2.
- An engine is never re-launched while its FSM is not IDLE. A new job for an engine whose FSM is in DONE waits until that completion is reported.
- q_count and sched_busy are registered and reflect the state after each cycle's push/pop.

Test Plan:
- Single CNN job, id=5; busy high from T+2 to T+11 -> eng_go=001 at T+1 only; done_valid with done_id=5, err=0 exactly once, 2 cycles after busy falls; sched_busy then returns to 0.
- Push CNN id=1, POOL id=2, then POOL id=3 with barrier=1; CNN busy 20 cycles, POOL busy 5 cycles ->
  - POOL go fires 1 cycle after CNN go;
  - id=2 completes before id=1;
  - id=3 go only after id=1 is reported.
- CNN and FCC busy fall in the same cycle -> done id(CNN) in cycle N, done id(FCC) in N+1; no loss.
- FCC job whose busy never rises, START_TIMEOUT=4 -> done_err=1 exactly 4 cycles after entering ARM; an illegal eng=3 job -> done_err=1 with no go.
- Push 9 commands to a stalled engine, CMD_DEPTH=8 -> cmd_ready=0 at q_count=8 and the 9th command is not accepted. Then drain -> exactly 8 done pulses, in order per engine.
- Assert rst_n=0 during RUN with 3 jobs queued -> all outputs reset immediately; no done_valid; q_count=0; cmd_ready=1 after release.
